// File: rtl/uclk_cmd_responder.sv
// ---------------------------------------------------------------------------
// uclk_cmd_responder
//
// Responder side of the user-clock frequency command CSR protocol.
// Software writes FREQ_CMD0 to request one IOPLL reconfiguration access
// (read, write, or masked read-modify-write). This block runs that access
// as an Avalon-MM master and reports the outcome in FREQ_STS0, together
// with the echoed sequence number and the synchronised PLL lock status.
// FREQ_CMD1 carries the user clock select.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in one Avalon phase before the access
//                   is abandoned and flagged in sts0[61]
//   RMW_MASK        bits taken from the command data on a masked write;
//                   the rest come from the value read back
//
// Ports
//   clk                 single clock for the CSR and Avalon-MM side
//   rst_n               asynchronous active-low reset
//   cmd0_wr/cmd0_wdata  FREQ_CMD0 write strobe and data
//   cmd1_wr/cmd1_wdata  FREQ_CMD1 write strobe and data
//   sts0                FREQ_STS0 read value
//   sel_clk             clock select, CMD1[32]
//   mgmt_reset          CMD0[56], registered
//   iopll_reset         CMD0[57], registered
//   avmm_rst_n          CMD0[52], registered
//   pll_locked          IOPLL lock, asynchronous to clk
//   avmm_*              Avalon-MM master to the IOPLL reconfig slave
// ---------------------------------------------------------------------------
module uclk_cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] RMW_MASK       = 32'h0000_01FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd0_wr,
    input  logic [63:0] cmd0_wdata,
    input  logic        cmd1_wr,
    input  logic [63:0] cmd1_wdata,
    output logic [63:0] sts0,
    output logic        sel_clk,
    output logic        mgmt_reset,
    output logic        iopll_reset,
    output logic        avmm_rst_n,
    input  logic        pll_locked,
    output logic [9:0]  avmm_address,
    output logic        avmm_write,
    output logic        avmm_read,
    output logic [31:0] avmm_writedata,
    input  logic [31:0] avmm_readdata,
    input  logic        avmm_readdatavalid,
    input  logic        avmm_waitrequest
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_DONE
    } state_t;

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // ---------------------------------------------------------------
    // CMD0 field decode
    // ---------------------------------------------------------------
    logic [31:0] cmd_data;
    logic [9:0]  cmd_addr;
    logic        cmd_write;
    logic [1:0]  cmd_seq;
    logic        cmd_mask;
    logic        cmd_rstn;

    assign cmd_data  = cmd0_wdata[31:0];
    assign cmd_addr  = cmd0_wdata[41:32];
    assign cmd_write = cmd0_wdata[44];
    assign cmd_seq   = cmd0_wdata[49:48];
    assign cmd_mask  = cmd0_wdata[51];
    assign cmd_rstn  = cmd0_wdata[52];

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd0_wdata[63:58], cmd0_wdata[55:53],
                               cmd0_wdata[50], cmd0_wdata[47:45],
                               cmd0_wdata[43:42], cmd1_wdata[63:33],
                               cmd1_wdata[31:0]};

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tmo_cnt;

    logic [31:0] data_q;
    logic [9:0]  addr_q;
    logic        write_q;
    logic        mask_q;
    logic [1:0]  seq_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [1:0]  last_seq;

    logic [31:0] sts_data;
    logic [9:0]  sts_addr;
    logic        sts_write;
    logic [1:0]  sts_seq;
    logic        sts_err;

    logic        lock_meta;
    logic        lock_sync;

    logic        start;
    logic        rmw;
    logic        abort;
    logic        tmo;
    logic        set_err;
    logic        rd_capture;

    // A new sequence number seen while idle is the only thing that starts
    // a transaction; anything else on CMD0 just refreshes the control bits.
    assign start = cmd0_wr && (state_q == ST_IDLE) && (cmd_seq != last_seq);
    assign rmw   = write_q && mask_q;

    // Dropping avmm_rst_n while busy kills the access immediately; the
    // request lines are gated off in the same cycle the flop goes low.
    assign abort = !avmm_rst_n;
    assign tmo   = (tmo_cnt == TMO_LAST);

    assign avmm_address   = addr_q;
    assign avmm_writedata = rmw ? ((rdata_q & ~RMW_MASK) | (data_q & RMW_MASK))
                                : data_q;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state and Avalon requests
    // ---------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        avmm_read  = 1'b0;
        avmm_write = 1'b0;
        set_err    = 1'b0;
        rd_capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && cmd_rstn) begin
                    state_d = (!cmd_write || cmd_mask) ? ST_RD_REQ : ST_WR_REQ;
                end
            end

            ST_RD_REQ: begin
                if (abort) begin
                    state_d = ST_DONE;
                    set_err = 1'b1;
                end else begin
                    avmm_read = 1'b1;
                    if (!avmm_waitrequest) begin
                        state_d = ST_RD_WAIT;
                    end else if (tmo) begin
                        state_d = ST_DONE;
                        set_err = 1'b1;
                    end
                end
            end

            ST_RD_WAIT: begin
                if (abort) begin
                    state_d = ST_DONE;
                    set_err = 1'b1;
                end else if (avmm_readdatavalid) begin
                    rd_capture = 1'b1;
                    state_d    = rmw ? ST_WR_REQ : ST_DONE;
                end else if (tmo) begin
                    state_d = ST_DONE;
                    set_err = 1'b1;
                end
            end

            ST_WR_REQ: begin
                if (abort) begin
                    state_d = ST_DONE;
                    set_err = 1'b1;
                end else begin
                    avmm_write = 1'b1;
                    if (!avmm_waitrequest) begin
                        state_d = ST_DONE;
                    end else if (tmo) begin
                        state_d = ST_DONE;
                        set_err = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Per-phase timeout counter: restarts on every state change and
    // saturates so it cannot wrap while parked in IDLE.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt <= '0;
        end else if (!tmo) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Control bits: follow every CMD0 write, busy or not
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avmm_rst_n  <= 1'b0;
            mgmt_reset  <= 1'b0;
            iopll_reset <= 1'b0;
        end else if (cmd0_wr) begin
            avmm_rst_n  <= cmd0_wdata[52];
            mgmt_reset  <= cmd0_wdata[56];
            iopll_reset <= cmd0_wdata[57];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_clk <= 1'b0;
        end else if (cmd1_wr) begin
            sel_clk <= cmd1_wdata[32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    // ---------------------------------------------------------------
    // Transaction context, read capture and status publication
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            mask_q    <= 1'b0;
            seq_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            last_seq  <= '0;
            sts_data  <= '0;
            sts_addr  <= '0;
            sts_write <= 1'b0;
            sts_seq   <= '0;
            sts_err   <= 1'b0;
        end else begin
            if (start) begin
                data_q  <= cmd_data;
                addr_q  <= cmd_addr;
                write_q <= cmd_write;
                mask_q  <= cmd_mask;
                seq_q   <= cmd_seq;
                err_q   <= 1'b0;
                sts_err <= 1'b0;
                // With the Avalon side held in reset there is nothing to
                // execute: acknowledge the sequence number straight away.
                if (!cmd_rstn) begin
                    sts_data  <= '0;
                    sts_addr  <= cmd_addr;
                    sts_write <= cmd_write;
                    sts_seq   <= cmd_seq;
                    last_seq  <= cmd_seq;
                end
            end

            if (set_err) begin
                err_q <= 1'b1;
            end

            if (rd_capture) begin
                rdata_q <= avmm_readdata;
            end

            if (state_q == ST_DONE) begin
                if (err_q) begin
                    sts_data <= '0;
                end else if (write_q && !mask_q) begin
                    sts_data <= data_q;
                end else begin
                    sts_data <= rdata_q;
                end
                sts_addr  <= addr_q;
                sts_write <= write_q;
                sts_seq   <= seq_q;
                sts_err   <= err_q;
                last_seq  <= seq_q;
            end
        end
    end

    // ---------------------------------------------------------------
    // FREQ_STS0 assembly
    // ---------------------------------------------------------------
    always_comb begin
        sts0        = '0;
        sts0[31:0]  = sts_data;
        sts0[41:32] = sts_addr;
        sts0[44]    = sts_write;
        sts0[49:48] = sts_seq;
        sts0[52]    = avmm_rst_n;
        sts0[56]    = mgmt_reset;
        sts0[57]    = iopll_reset;
        sts0[60]    = lock_sync;
        sts0[61]    = sts_err;
    end

endmodule

// File: tb/tb_uclk_cmd_responder.sv
module tb_uclk_cmd_responder;

    localparam logic [31:0] MASK = 32'h0000_01FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd0_wr = 1'b0;
    logic [63:0] cmd0_wdata = '0;
    logic        cmd1_wr = 1'b0;
    logic [63:0] cmd1_wdata = '0;
    logic [63:0] sts0;
    logic        sel_clk;
    logic        mgmt_reset;
    logic        iopll_reset;
    logic        avmm_rst_n;
    logic        pll_locked = 1'b0;
    logic [9:0]  avmm_address;
    logic        avmm_write;
    logic        avmm_read;
    logic [31:0] avmm_writedata;
    logic [31:0] avmm_readdata = '0;
    logic        avmm_readdatavalid = 1'b0;
    logic        avmm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    uclk_cmd_responder #(
        .TIMEOUT_CYCLES(1024),
        .RMW_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd0_wr(cmd0_wr),
        .cmd0_wdata(cmd0_wdata),
        .cmd1_wr(cmd1_wr),
        .cmd1_wdata(cmd1_wdata),
        .sts0(sts0),
        .sel_clk(sel_clk),
        .mgmt_reset(mgmt_reset),
        .iopll_reset(iopll_reset),
        .avmm_rst_n(avmm_rst_n),
        .pll_locked(pll_locked),
        .avmm_address(avmm_address),
        .avmm_write(avmm_write),
        .avmm_read(avmm_read),
        .avmm_writedata(avmm_writedata),
        .avmm_readdata(avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid),
        .avmm_waitrequest(avmm_waitrequest)
    );

    // Slave memory (environment) and reference memory (model).
    logic [31:0] s_mem [1024];
    logic [31:0] m_mem [1024];

    // Slave behaviour knobs and observation counters.
    bit          s_stuck = 0;
    int          s_stall_fixed = -1;
    int          n_rd = 0;
    int          n_wr = 0;
    int          req_hi = 0;
    logic [31:0] last_wdata = '0;

    // Reference model state.
    logic [31:0] m_data;
    logic [9:0]  m_addr;
    logic        m_write;
    logic [1:0]  m_seq;
    logic [1:0]  m_last;
    logic        m_err;
    logic        m_rstn;
    logic        m_mgmt;
    logic        m_iopll;
    int          exp_rd = 0;
    int          exp_wr = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_addr = '0; m_write = 0; m_seq = '0; m_last = '0;
        m_err = 0; m_rstn = 0; m_mgmt = 0; m_iopll = 0;
    endtask

    function automatic logic [63:0] exp_sts();
        logic [63:0] v;
        v = '0;
        v[31:0]  = m_data;
        v[41:32] = m_addr;
        v[44]    = m_write;
        v[49:48] = m_seq;
        v[52]    = m_rstn;
        v[56]    = m_mgmt;
        v[57]    = m_iopll;
        v[60]    = pll_locked;
        v[61]    = m_err;
        return v;
    endfunction

    // Unused CMD0 bits carry random junk to prove they are ignored.
    function automatic logic [63:0] mk_cmd(input logic [1:0] seq, input logic [9:0] addr,
                                           input logic [31:0] data, input logic wr,
                                           input logic mask, input logic rstn,
                                           input logic mgmt, input logic iopll);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[31:0] = data; w[41:32] = addr; w[44] = wr; w[49:48] = seq;
        w[51] = mask; w[52] = rstn; w[56] = mgmt; w[57] = iopll;
        return w;
    endfunction

    task automatic model_ctrl(input logic [63:0] w);
        m_rstn = w[52]; m_mgmt = w[56]; m_iopll = w[57];
    endtask

    // Effect of a CMD0 write that arrives while the responder is idle.
    task automatic model_exec(input logic [63:0] w, output bit started);
        logic [9:0]  a;
        logic [31:0] old;
        a = w[41:32];
        started = (w[49:48] != m_last);
        if (!started) return;
        m_err = 0; m_seq = w[49:48]; m_last = w[49:48];
        m_addr = a; m_write = w[44];
        if (!w[52]) begin
            m_data = '0;
        end else if (!w[44]) begin
            m_data = m_mem[a]; exp_rd++;
        end else if (w[51]) begin
            old = m_mem[a];
            m_data = old;
            m_mem[a] = (old & ~MASK) | (w[31:0] & MASK);
            exp_rd++; exp_wr++;
        end else begin
            m_mem[a] = w[31:0]; m_data = w[31:0]; exp_wr++;
        end
    endtask

    task automatic send0(input logic [63:0] w);
        @(negedge clk);
        cmd0_wr = 1; cmd0_wdata = w;
        @(negedge clk);
        cmd0_wr = 0;
    endtask

    task automatic wait_seq(input logic [1:0] seq);
        for (int i = 0; i < 3000 && sts0[49:48] !== seq; i++) @(negedge clk);
    endtask

    task automatic run_cmd(input string tag, input logic [63:0] w);
        bit st;
        model_ctrl(w);
        model_exec(w, st);
        send0(w);
        if (st) wait_seq(w[49:48]);
        else repeat (4) @(negedge clk);
        check({tag, "_sts0"}, sts0, exp_sts());
        check({tag, "_nrd"}, 64'(n_rd), 64'(exp_rd));
        check({tag, "_nwr"}, 64'(n_wr), 64'(exp_wr));
    endtask

    // Avalon slave: optional stalls, 1..3 cycle read latency, or stuck forever.
    task automatic slave_loop();
        bit          in_req = 0;
        int          stall_left = 0;
        bit          rd_pend = 0;
        int          rd_cnt = 0;
        logic [9:0]  rd_addr = '0;
        forever begin
            @(negedge clk);
            avmm_readdatavalid = 0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    avmm_readdatavalid = 1;
                    avmm_readdata = s_mem[rd_addr];
                    rd_pend = 0;
                end else rd_cnt--;
            end
            if (!rst_n || !(avmm_read || avmm_write)) begin
                in_req = 0; avmm_waitrequest = 0;
                if (!rst_n) rd_pend = 0;
            end else begin
                req_hi++;
                if (!in_req) begin
                    in_req = 1;
                    stall_left = (s_stall_fixed >= 0) ? s_stall_fixed : int'($urandom_range(0, 3));
                end
                if (s_stuck || stall_left > 0) begin
                    avmm_waitrequest = 1;
                    if (stall_left > 0) stall_left--;
                end else begin
                    avmm_waitrequest = 0; in_req = 0;
                    if (avmm_read) begin
                        n_rd++; rd_pend = 1; rd_addr = avmm_address;
                        rd_cnt = int'($urandom_range(0, 2));
                    end else begin
                        n_wr++; s_mem[avmm_address] = avmm_writedata;
                        last_wdata = avmm_writedata;
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] w;
        logic [63:0] w2;
        logic [31:0] v;
        bit          st;
        int          hi0;
        int          nr0;

        for (int i = 0; i < 1024; i++) begin
            v = $urandom; s_mem[i] = v; m_mem[i] = v;
        end
        s_mem[10'h58] = 32'hA5;       m_mem[10'h58] = 32'hA5;
        s_mem[10'h40] = 32'hFFFF0000; m_mem[10'h40] = 32'hFFFF0000;
        model_reset();

        rst_n = 0;
        fork slave_loop(); join_none
        repeat (3) @(negedge clk);
        check("reset_sts0", sts0, exp_sts());
        check("reset_outs", {58'b0, sel_clk, mgmt_reset, iopll_reset, avmm_rst_n, avmm_read, avmm_write}, 64'h0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Plain write
        run_cmd("wr10", mk_cmd(2'd1, 10'h10, 32'h3, 1, 0, 1, 0, 0));
        check("wr10_wdata", 64'(last_wdata), 64'h3);

        // Read with 3 stall cycles
        s_stall_fixed = 3;
        run_cmd("rd58", mk_cmd(2'd2, 10'h58, 32'h0, 0, 0, 1, 0, 0));
        s_stall_fixed = -1;

        // Repeated seq: control bits only
        run_cmd("rep2", mk_cmd(2'd2, 10'h11, 32'h1234, 1, 0, 1, 1, 0));

        // New seq while busy is dropped
        s_stall_fixed = 6;
        w = mk_cmd(2'd3, 10'h20, 32'h0, 0, 0, 1, 0, 0);
        model_ctrl(w); model_exec(w, st);
        send0(w);
        w2 = mk_cmd(2'd0, 10'h21, 32'hDEAD, 1, 0, 1, 1, 1);
        model_ctrl(w2);
        send0(w2);
        wait_seq(2'd3);
        check("busy_sts0", sts0, exp_sts());
        check("busy_nwr", 64'(n_wr), 64'(exp_wr));
        check("busy_nrd", 64'(n_rd), 64'(exp_rd));
        s_stall_fixed = -1;

        // Masked write
        run_cmd("rmw40", mk_cmd(2'd1, 10'h40, 32'h1FF, 1, 1, 1, 0, 0));
        check("rmw40_wdata", 64'(last_wdata), 64'hFFFF01FF);

        // Timeout: slave never releases waitrequest
        s_stuck = 1;
        hi0 = req_hi; nr0 = n_rd;
        w = mk_cmd(2'd2, 10'h33, 32'h0, 0, 0, 1, 0, 0);
        model_ctrl(w);
        m_err = 1; m_data = '0; m_seq = 2'd2; m_last = 2'd2; m_addr = 10'h33; m_write = 0;
        send0(w);
        wait_seq(2'd2);
        check("tmo_sts0", sts0, exp_sts());
        check("tmo_req_cycles", 64'(req_hi - hi0), 64'd1024);
        check("tmo_nrd", 64'(n_rd - nr0), 64'd0);
        check("tmo_read_low", 64'(avmm_read), 64'd0);
        s_stuck = 0;

        // Avalon reset held: immediate echo, err cleared
        run_cmd("norst", mk_cmd(2'd3, 10'h44, 32'h55, 1, 0, 0, 0, 1));
        check("norst_pin", 64'(avmm_rst_n), 64'd0);

        // avmm_rst_n falling mid-transaction aborts
        s_stuck = 1;
        w = mk_cmd(2'd0, 10'h77, 32'h9, 1, 0, 1, 0, 0);
        model_ctrl(w);
        m_err = 1; m_data = '0; m_seq = 2'd0; m_last = 2'd0; m_addr = 10'h77; m_write = 1;
        send0(w);
        repeat (5) @(negedge clk);
        w2 = mk_cmd(2'd1, 10'h00, 32'h0, 0, 0, 0, 1, 0);
        model_ctrl(w2);
        send0(w2);
        wait_seq(2'd0);
        check("abort_sts0", sts0, exp_sts());
        s_stuck = 0;

        // PLL lock synchroniser
        @(negedge clk); pll_locked = 1;
        @(negedge clk); check("lock_rise_1", 64'(sts0[60]), 64'd0);
        @(negedge clk); check("lock_rise_2", 64'(sts0[60]), 64'd1);
        pll_locked = 0;
        @(negedge clk); check("lock_fall_1", 64'(sts0[60]), 64'd1);
        @(negedge clk); check("lock_fall_2", 64'(sts0[60]), 64'd0);
        pll_locked = 1;
        repeat (2) @(negedge clk);

        // Clock select
        cmd1_wr = 1; cmd1_wdata = {$urandom, $urandom}; cmd1_wdata[32] = 1;
        @(negedge clk); cmd1_wr = 0;
        check("sel_clk_1", 64'(sel_clk), 64'd1);
        cmd1_wr = 1; cmd1_wdata = {$urandom, $urandom}; cmd1_wdata[32] = 0;
        @(negedge clk); cmd1_wr = 0;
        check("sel_clk_0", 64'(sel_clk), 64'd0);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            w = mk_cmd(2'($urandom_range(0, 3)), 10'($urandom), $urandom,
                       1'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0),
                       1'($urandom), 1'($urandom));
            run_cmd("rand", w);
        end

        // Asynchronous reset in the middle of a read
        s_stall_fixed = 20;
        w = mk_cmd(m_last + 2'd1, 10'h66, 32'h0, 0, 0, 1, 1, 1);
        send0(w);
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        check("arst_sts0", sts0, 64'h0);
        check("arst_outs", {59'b0, mgmt_reset, iopll_reset, avmm_rst_n, avmm_read, avmm_write}, 64'h0);
        @(negedge clk); rst_n = 1;
        s_stall_fixed = -1;
        model_reset();
        repeat (3) @(negedge clk);
        check("arst_after", sts0, exp_sts());
        run_cmd("arst_seq0", mk_cmd(2'd0, 10'h12, 32'h7, 1, 0, 1, 0, 0));
        run_cmd("arst_seq1", mk_cmd(2'd1, 10'h12, 32'h7, 1, 0, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
